// File: rtl/bcd_tally_pkg.sv
// Shared BCD constants and the single-digit increment used by the tally carry chain.
package bcd_tally_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Returns {carry_out, next_digit}; a set carry on digit 9 wraps it to 0.
  function automatic logic [BCD_W:0] bcd_inc(input logic [BCD_W-1:0] digit, input logic cin);
    logic [BCD_W:0] r;
    if (!cin) begin
      r = {1'b0, digit};
    end else if (digit >= BCD_MAX) begin
      r = {1'b1, {BCD_W{1'b0}}};
    end else begin
      r = {1'b0, digit + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_stable_filter.sv
// Brings the asynchronous ripple count into clk and reports a value once it has
// been seen unchanged on enough consecutive edges.
module sync_stable_filter
  import bcd_tally_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int W             = BCD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] cand,
  output logic         accept_pulse
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
  localparam logic [RUN_W-1:0] RUN_ACC = RUN_W'(STABLE_CYCLES - 1);

  logic [W-1:0]     sync_q [SYNC_STAGES];
  logic [W-1:0]     sync_d [SYNC_STAGES];
  logic [W-1:0]     s;
  logic [W-1:0]     cand_q, cand_d;
  logic [RUN_W-1:0] run_q, run_d;

  always_comb begin
    sync_d[0] = din;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Saturating run length so a held value fires exactly once.
  always_comb begin
    cand_d = cand_q;
    run_d  = run_q;
    if (s != cand_q) begin
      cand_d = s;
      run_d  = RUN_W'(1);
    end else if (run_q != RUN_MAX) begin
      run_d = run_q + RUN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      cand_q <= '0;
      run_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cand_q <= cand_d;
      run_q  <= run_d;
    end
  end

  assign cand         = cand_q;
  assign accept_pulse = (s == cand_q) && (run_q == RUN_ACC);

endmodule

// File: rtl/bcd_rip_cntr_sync_tally.sv
// Extends a filtered single-decade ripple count into a multi-digit BCD tally,
// with an update strobe and sticky overflow / illegal-code flags.
module bcd_rip_cntr_sync_tally
  import bcd_tally_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BCD_W-1:0]            count_in,
  input  logic                        clr,
  output logic [BCD_W*NUM_DIGITS-1:0] tally,
  output logic                        upd,
  output logic                        ovf,
  output logic                        bcd_err
);

  localparam int TALLY_W = BCD_W * NUM_DIGITS;
  localparam int UP_W    = BCD_W * (NUM_DIGITS - 1);

  logic [BCD_W-1:0]   cand;
  logic               accept_pulse;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [TALLY_W-1:0] tally_q, tally_d;
  logic               upd_q, upd_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic               take, legal, wrap, top_cout;
  logic [UP_W-1:0]    upper_nxt;

  sync_stable_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .W            (BCD_W)
  ) u_filter (
    .clk         (clk),
    .rst         (rst),
    .din         (count_in),
    .cand        (cand),
    .accept_pulse(accept_pulse)
  );

  assign take  = accept_pulse && (cand != acc_q);
  assign legal = (cand <= BCD_MAX);
  // A smaller accepted value means the decade rolled over (possibly after missed counts).
  assign wrap  = take && legal && (cand < acc_q);

  for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_dig
    logic             cin;
    logic             cout;
    logic [BCD_W-1:0] nxt;
    if (i == 1) begin : g_first
      assign cin = wrap;
    end else begin : g_rest
      assign cin = g_dig[i-1].cout;
    end
    assign {cout, nxt} = bcd_inc(tally_q[BCD_W*i +: BCD_W], cin);
    assign upper_nxt[BCD_W*(i-1) +: BCD_W] = nxt;
  end

  assign top_cout = g_dig[NUM_DIGITS-1].cout;

  always_comb begin
    tally_d = tally_q;
    acc_d   = acc_q;
    upd_d   = 1'b0;
    ovf_d   = ovf_q;
    err_d   = err_q;
    if (take) begin
      if (legal) begin
        acc_d                = cand;
        tally_d[BCD_W-1:0]   = cand;
        upd_d                = 1'b1;
        if (wrap) begin
          tally_d[TALLY_W-1:BCD_W] = upper_nxt;
          if (top_cout) begin
            ovf_d = 1'b1;
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
    // Clear wins over a same-edge carry; the ones digit still tracks the count.
    if (clr) begin
      tally_d[TALLY_W-1:BCD_W] = '0;
      ovf_d                    = 1'b0;
      err_d                    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      tally_q <= '0;
      upd_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      tally_q <= tally_d;
      upd_q   <= upd_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign tally   = tally_q;
  assign upd     = upd_q;
  assign ovf     = ovf_q;
  assign bcd_err = err_q;

endmodule
